// File: rtl/uart_rx_cmd_fifo.sv
// Receive-side un-escaper and command/data tagger in front of a first-word-fall-through FIFO.
// Each FIFO entry is {cmd, byte}; the FIFO head is presented to the TAP decoder and popped by READ_I.
module uart_rx_cmd_fifo #(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  ESC_BYTE = 8'h1B
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic [7:0] RX_DATA_I,
    input  logic       RX_VALID_I,
    input  logic       RX_ERROR_I,
    input  logic       CLEAR_I,
    input  logic       READ_I,
    output logic [7:0] DATA_REC_O,
    output logic       CMD_REC_O,
    output logic       RX_EMPTY_O,
    output logic       RX_FULL_O,
    output logic       OVERFLOW_O,
    output logic       RX_ERR_O
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, ESC_SEEN} state_e;

    state_e        state_q, state_d;
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, err_q, err_d;
    logic          push_req, push_cmd, push, pop, full, empty;
    logic [8:0]    head;

    // Escape FSM: decides whether the incoming byte is pushed and how it is tagged.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        push_cmd = 1'b0;
        if (RX_VALID_I) begin
            if (RX_ERROR_I) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (RX_DATA_I == ESC_BYTE) state_d = ESC_SEEN;
                        else push_req = 1'b1;
                    end
                    ESC_SEEN: begin
                        push_req = 1'b1;
                        push_cmd = (RX_DATA_I != ESC_BYTE);
                        state_d  = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        if (CLEAR_I) begin
            state_d  = IDLE;
            push_req = 1'b0;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = READ_I & ~empty & ~CLEAR_I;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push  = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push_req & full & ~pop);
        err_d    = err_q | (RX_VALID_I & RX_ERROR_I);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (CLEAR_I) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge CLK_I) begin
        if (push) mem_q[wr_ptr_q] <= {push_cmd, RX_DATA_I};
    end

    assign head       = mem_q[rd_ptr_q];
    assign DATA_REC_O = empty ? 8'h00 : head[7:0];
    assign CMD_REC_O  = ~empty & head[8];
    assign RX_EMPTY_O = empty;
    assign RX_FULL_O  = full;
    assign OVERFLOW_O = ovf_q;
    assign RX_ERR_O   = err_q;

endmodule
